// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: op and condition encodings,
// condition-code bit positions, reset value and condition evaluation.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_LE = 3'd1;
  localparam logic [2:0] COND_L  = 3'd2;
  localparam logic [2:0] COND_E  = 3'd3;
  localparam logic [2:0] COND_NE = 3'd4;
  localparam logic [2:0] COND_GE = 3'd5;
  localparam logic [2:0] COND_G  = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RST = 3'b100;

  function automatic logic cond_eval(
    input logic [2:0] c,
    input logic [2:0] f
  );
    logic lt;
    logic r;
    lt = f[CC_SF] ^ f[CC_OF];
    r  = 1'b0;
    unique case (1'b1)
      (c == COND_AL): r = 1'b1;
      (c == COND_LE): r = lt | f[CC_ZF];
      (c == COND_L):  r = lt;
      (c == COND_E):  r = f[CC_ZF];
      (c == COND_NE): r = !f[CC_ZF];
      (c == COND_GE): r = !lt;
      (c == COND_G):  r = !lt && !f[CC_ZF];
      (c == COND_NV): r = 1'b0;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit AND/XOR/ADD/SUB datapath with signed overflow.
// Ports: op, a, b in; result (wrap-around), ovf out.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         ovf
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (1'b1)
      (op == OP_AND): result = a & b;
      (op == OP_XOR): result = a ^ b;
      (op == OP_ADD): begin
        result = sum;
        ovf = (a[W-1] == b[W-1]) &&
              (sum[W-1] != a[W-1]);
      end
      (op == OP_SUB): begin
        result = diff;
        ovf = (a[W-1] != b[W-1]) &&
              (diff[W-1] != a[W-1]);
      end
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: valid/ready request in, 2-entry in-order response
// FIFO out, architectural {ZF,SF,OF} condition codes.
// Ports: clk, rst_n (sync, active-low), req_* handshake + operands,
// rsp_* handshake + result/cond, cc. Macro ALU_ISSUE_CC_EN enables cc.
module alu_issue
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_setcc,
  input  logic [2:0]   req_cond,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_cond,
  output logic [2:0]   cc
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] res0_q, res0_d;
  logic [W-1:0] res1_q, res1_d;
  logic         cnd0_q, cnd0_d;
  logic         cnd1_q, cnd1_d;

  logic         accept;
  logic         pop;
  logic [W-1:0] core_res;
  logic         core_ovf;
  logic         new_cond;

  alu_core #(
    .W(W)
  ) u_core (
    .op     (req_op),
    .a      (req_a),
    .b      (req_b),
    .result (core_res),
    .ovf    (core_ovf)
  );

  assign req_ready  = (state_q != ST_FULL);
  assign rsp_valid  = (state_q != ST_EMPTY);
  assign rsp_result = res0_q;
  assign rsp_cond   = cnd0_q;
  assign accept     = req_valid && req_ready;
  assign pop        = rsp_valid && rsp_ready;

`ifdef ALU_ISSUE_CC_EN
  logic [2:0] cc_q, cc_d;
  logic [2:0] flags_new;
  logic [2:0] cc_eff;

  assign flags_new = {core_res == '0, core_res[W-1], core_ovf};
  // Condition sees this op's own flags when it sets them.
  assign cc_eff    = req_setcc ? flags_new : cc_q;
  assign new_cond  = cond_eval(req_cond, cc_eff);
  assign cc        = cc_q;

  always_comb begin
    cc_d = cc_q;
    if (accept && req_setcc) cc_d = flags_new;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= CC_RST;
    else        cc_q <= cc_d;
  end
`else
  logic unused_cc;

  assign unused_cc = ^{req_setcc, req_cond, core_ovf};
  assign new_cond  = 1'b1;
  assign cc        = CC_RST;
`endif

  always_comb begin
    state_d = state_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    cnd0_d  = cnd0_q;
    cnd1_d  = cnd1_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          res0_d  = core_res;
          cnd0_d  = new_cond;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          res0_d = core_res;
          cnd0_d = new_cond;
        end else if (accept) begin
          res1_d  = core_res;
          cnd1_d  = new_cond;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // No accept possible here; pop shifts tail into head.
        if (pop) begin
          res0_d  = res1_q;
          cnd0_d  = cnd1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      res0_q  <= '0;
      res1_q  <= '0;
      cnd0_q  <= 1'b0;
      cnd1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      cnd0_q  <= cnd0_d;
      cnd1_q  <= cnd1_d;
    end
  end

endmodule
